// File: rtl/cis_cds_pkg.sv
// Shared types and widths for the CIS correlated-double-sampling accumulator.
// Optional min/max result fields are controlled by CIS_CDS_MINMAX_EN.
package cis_cds_pkg;

  localparam int unsigned ADC_WIDTH   = 16;
  localparam int unsigned ACC_WIDTH   = 28;
  localparam int unsigned DIFF_WIDTH  = ADC_WIDTH + 1;
  localparam int unsigned PIX_WIDTH   = 4;
  localparam int unsigned NSAMP_WIDTH = 11;
  localparam int unsigned SKIP_WIDTH  = 10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_PED = 2'd1,
    WAIT_SIG = 2'd2,
    PUSH     = 2'd3
  } cds_state_e;

  typedef struct packed {
    logic [ACC_WIDTH-1:0]   data;
    logic [PIX_WIDTH-1:0]   pixel;
    logic [NSAMP_WIDTH-1:0] nsamp;
`ifdef CIS_CDS_MINMAX_EN
    logic [DIFF_WIDTH-1:0]  min_v;
    logic [DIFF_WIDTH-1:0]  max_v;
`endif
  } cds_result_t;

endpackage

// File: rtl/cis_cds_outbuf.sv
// Small valid/ready FIFO holding pixel results on their way to the framer.
module cis_cds_outbuf
  import cis_cds_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_push,
  input  cds_result_t i_data,
  output logic        o_valid,
  input  logic        i_ready,
  output cds_result_t o_data,
  output logic        o_full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  cds_result_t      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_pop;
  logic w_wr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_valid = (r_count != '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_data  = r_mem[r_rd_ptr];
  assign w_pop   = o_valid & i_ready;
  // A pop in the same cycle frees the slot, so a push into a full buffer still lands
  assign w_wr    = i_push & (~o_full | w_pop);

  // Storage, pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_wr && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_wr && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/cis_cds_accumulator.sv
// Receive-side CDS accumulator: pairs PED/SIG ADC captures, sums skipper
// differences per pixel and hands results to a small output buffer.
// Define CIS_CDS_MINMAX_EN to add per-pixel min/max difference outputs.
module cis_cds_accumulator
  import cis_cds_pkg::*;
#(
  parameter int unsigned PIXEL_CLUSTER_SIZE = 16,
  parameter int unsigned OUT_DEPTH          = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   integration,
  input  logic                   global_shutter,
  input  logic [SKIP_WIDTH-1:0]  skip_samples,
  input  logic                   sprocket_PED,
  input  logic                   sprocket_SIG,
  input  logic [ADC_WIDTH-1:0]   adc_data,
  input  logic                   adc_valid,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_WIDTH-1:0]   out_data,
  output logic [PIX_WIDTH-1:0]   out_pixel,
  output logic [NSAMP_WIDTH-1:0] out_nsamp,
`ifdef CIS_CDS_MINMAX_EN
  output logic [DIFF_WIDTH-1:0]  out_min,
  output logic [DIFF_WIDTH-1:0]  out_max,
`endif
  output logic                   err_proto,
  output logic                   err_overflow,
  input  logic                   err_clear
);

  localparam logic [PIX_WIDTH-1:0] PIX_LAST = PIX_WIDTH'(PIXEL_CLUSTER_SIZE - 1);

  cds_state_e             r_state;
  cds_state_e             w_state_nxt;
  logic                   r_int_d, r_ped_d, r_sig_d, r_ped_arm, r_sig_arm;
  logic [ADC_WIDTH-1:0]   r_ped;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic [NSAMP_WIDTH-1:0] r_pair_cnt, r_nsamp_tgt;
  logic [PIX_WIDTH-1:0]   r_pixel;
  logic                   r_gs, r_err_proto, r_err_overflow;
`ifdef CIS_CDS_MINMAX_EN
  logic [DIFF_WIDTH-1:0]  r_min, r_max;
`endif

  logic w_int_rise, w_ped_cap, w_sig_cap;
  logic w_start, w_ped_load, w_acc_add, w_push, w_pixel_inc, w_proto_set;
  logic w_buf_valid, w_buf_full, w_buf_pop, w_overflow;
  logic [DIFF_WIDTH-1:0] w_diff;
  logic [ACC_WIDTH-1:0]  w_diff_ext;
  cds_result_t w_res, w_buf_data;

  assign w_int_rise = integration & ~r_int_d;
  // Only the first valid after a strobe rising edge is a capture
  assign w_ped_cap  = adc_valid & sprocket_PED & (r_ped_arm | ~r_ped_d);
  assign w_sig_cap  = adc_valid & sprocket_SIG & (r_sig_arm | ~r_sig_d);
  assign w_diff     = {1'b0, adc_data} - {1'b0, r_ped};
  assign w_diff_ext = {{(ACC_WIDTH - DIFF_WIDTH){w_diff[DIFF_WIDTH-1]}}, w_diff};

  // Edge-detect copies and capture arming for strobes and integration
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_int_d   <= 1'b0;
      r_ped_d   <= 1'b0;
      r_sig_d   <= 1'b0;
      r_ped_arm <= 1'b0;
      r_sig_arm <= 1'b0;
    end else begin
      r_int_d   <= integration;
      r_ped_d   <= sprocket_PED;
      r_sig_d   <= sprocket_SIG;
      r_ped_arm <= sprocket_PED & (r_ped_arm | ~r_ped_d) & ~w_ped_cap;
      r_sig_arm <= sprocket_SIG & (r_sig_arm | ~r_sig_d) & ~w_sig_cap;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and datapath controls; a frame start overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_ped_load  = 1'b0;
    w_acc_add   = 1'b0;
    w_push      = 1'b0;
    w_pixel_inc = 1'b0;
    w_proto_set = 1'b0;
    if (w_int_rise) begin
      w_start     = 1'b1;
      w_proto_set = (r_state != IDLE);
      w_state_nxt = WAIT_PED;
    end else begin
      case (r_state)
        IDLE: w_state_nxt = IDLE;
        WAIT_PED: begin
          if (w_ped_cap) begin
            w_ped_load  = 1'b1;
            w_state_nxt = WAIT_SIG;
          end else if (w_sig_cap) begin
            w_proto_set = 1'b1;
          end
        end
        WAIT_SIG: begin
          if (w_sig_cap) begin
            w_acc_add   = 1'b1;
            w_state_nxt = (r_pair_cnt + NSAMP_WIDTH'(1) == r_nsamp_tgt) ? PUSH : WAIT_PED;
          end
        end
        PUSH: begin
          w_push = 1'b1;
          if (r_gs && (r_pixel < PIX_LAST)) begin
            w_pixel_inc = 1'b1;
            w_state_nxt = WAIT_PED;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Frame configuration, pedestal, accumulator and pixel counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_nsamp_tgt <= '0;
      r_gs        <= 1'b0;
      r_ped       <= '0;
      r_acc       <= '0;
      r_pair_cnt  <= '0;
      r_pixel     <= '0;
`ifdef CIS_CDS_MINMAX_EN
      r_min       <= '0;
      r_max       <= '0;
`endif
    end else if (w_start) begin
      r_nsamp_tgt <= NSAMP_WIDTH'(skip_samples) + NSAMP_WIDTH'(1);
      r_gs        <= global_shutter;
      r_acc       <= '0;
      r_pair_cnt  <= '0;
      r_pixel     <= '0;
`ifdef CIS_CDS_MINMAX_EN
      r_min       <= '0;
      r_max       <= '0;
`endif
    end else begin
      if (w_ped_load) r_ped <= adc_data;
      if (w_acc_add) begin
        r_acc      <= r_acc + w_diff_ext;
        r_pair_cnt <= r_pair_cnt + NSAMP_WIDTH'(1);
`ifdef CIS_CDS_MINMAX_EN
        if (r_pair_cnt == '0 || $signed(w_diff) < $signed(r_min)) r_min <= w_diff;
        if (r_pair_cnt == '0 || $signed(w_diff) > $signed(r_max)) r_max <= w_diff;
`endif
      end
      if (w_push) begin
        r_acc      <= '0;
        r_pair_cnt <= '0;
`ifdef CIS_CDS_MINMAX_EN
        r_min      <= '0;
        r_max      <= '0;
`endif
        if (w_pixel_inc) r_pixel <= r_pixel + PIX_WIDTH'(1);
      end
    end
  end

  // Result record written at PUSH
  always_comb begin
`ifdef CIS_CDS_MINMAX_EN
    w_res = '{data: r_acc, pixel: r_pixel, nsamp: r_pair_cnt, min_v: r_min, max_v: r_max};
`else
    w_res = '{data: r_acc, pixel: r_pixel, nsamp: r_pair_cnt};
`endif
  end

  assign w_buf_pop  = w_buf_valid & out_ready;
  assign w_overflow = w_push & w_buf_full & ~w_buf_pop;

  // Sticky error flags; clear wins over a same-cycle set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_proto    <= 1'b0;
      r_err_overflow <= 1'b0;
    end else if (err_clear) begin
      r_err_proto    <= 1'b0;
      r_err_overflow <= 1'b0;
    end else begin
      if (w_proto_set) r_err_proto    <= 1'b1;
      if (w_overflow)  r_err_overflow <= 1'b1;
    end
  end

  cis_cds_outbuf #(.DEPTH(OUT_DEPTH)) u_outbuf (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_res),
    .o_valid (w_buf_valid),
    .i_ready (out_ready),
    .o_data  (w_buf_data),
    .o_full  (w_buf_full)
  );

  assign out_valid    = w_buf_valid;
  assign out_data     = w_buf_data.data;
  assign out_pixel    = w_buf_data.pixel;
  assign out_nsamp    = w_buf_data.nsamp;
`ifdef CIS_CDS_MINMAX_EN
  assign out_min      = w_buf_data.min_v;
  assign out_max      = w_buf_data.max_v;
`endif
  assign err_proto    = r_err_proto;
  assign err_overflow = r_err_overflow;

endmodule

// File: tb/tb_cis_cds_accumulator.sv
// Directed self-checking bench for cis_cds_accumulator.
module tb_cis_cds_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        integration;
  logic        global_shutter;
  logic [9:0]  skip_samples;
  logic        sprocket_PED;
  logic        sprocket_SIG;
  logic [15:0] adc_data;
  logic        adc_valid;
  logic        out_valid;
  logic        out_ready;
  logic [27:0] out_data;
  logic [3:0]  out_pixel;
  logic [10:0] out_nsamp;
  logic        err_proto;
  logic        err_overflow;
  logic        err_clear;
`ifdef CIS_CDS_MINMAX_EN
  logic [16:0] out_min;
  logic [16:0] out_max;
`endif

  cis_cds_accumulator dut (
    .clk            (clk),
    .reset          (reset),
    .integration    (integration),
    .global_shutter (global_shutter),
    .skip_samples   (skip_samples),
    .sprocket_PED   (sprocket_PED),
    .sprocket_SIG   (sprocket_SIG),
    .adc_data       (adc_data),
    .adc_valid      (adc_valid),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_pixel      (out_pixel),
    .out_nsamp      (out_nsamp),
`ifdef CIS_CDS_MINMAX_EN
    .out_min        (out_min),
    .out_max        (out_max),
`endif
    .err_proto      (err_proto),
    .err_overflow   (err_overflow),
    .err_clear      (err_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [27:0] data;
    logic [3:0]  pix;
    logic [10:0] ns;
    int          cyc;
  } res_t;

  typedef struct {
    logic [15:0] ped;
    logic [15:0] sig;
    logic [27:0] exp_data;
  } vec_t;

  res_t q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_sig_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every completed transfer, sampled mid-low-phase
  always @(negedge clk) begin
    #1;
    if (!reset && out_valid && out_ready)
      q.push_back('{data: out_data, pix: out_pixel, ns: out_nsamp, cyc: cyc});
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    integration = 1'b0; global_shutter = 1'b0; skip_samples = '0;
    sprocket_PED = 1'b0; sprocket_SIG = 1'b0; adc_data = '0; adc_valid = 1'b0;
    out_ready = 1'b1; err_clear = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    q.delete();
  endtask

  task automatic start_frame(input logic [9:0] skip, input logic gs);
    @(negedge clk);
    integration = 1'b0; skip_samples = skip; global_shutter = gs;
    @(negedge clk);
    integration = 1'b1;
    @(negedge clk);
  endtask

  task automatic strobe(input bit is_sig, input logic [15:0] val, input bit extra);
    @(negedge clk);
    if (is_sig) sprocket_SIG = 1'b1; else sprocket_PED = 1'b1;
    @(negedge clk);
    adc_valid = 1'b1; adc_data = val;
    if (is_sig) last_sig_cyc = cyc;
    @(negedge clk);
    adc_valid = extra; adc_data = 16'hBEEF;
    @(negedge clk);
    adc_valid = 1'b0;
    @(negedge clk);
    sprocket_PED = 1'b0; sprocket_SIG = 1'b0;
  endtask

  task automatic pair(input logic [15:0] ped, input logic [15:0] sig, input bit extra);
    strobe(1'b0, ped, extra);
    strobe(1'b1, sig, extra);
  endtask

  task automatic get_result(input string nm, output res_t r);
    int n;
    n = 0;
    r = '{data: '0, pix: '0, ns: '0, cyc: 0};
    while (q.size() == 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (q.size() == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_timeout: got no result expected one within 100 cycles", nm);
    end else begin
      r = q.pop_front();
    end
  endtask

  vec_t tbl[5];
  res_t r;

  initial begin
    tbl[0] = '{ped: 16'd100,   sig: 16'd350,   exp_data: 28'd250};
    tbl[1] = '{ped: 16'd350,   sig: 16'd100,   exp_data: 28'hFFFFF06};
    tbl[2] = '{ped: 16'd0,     sig: 16'd65535, exp_data: 28'd65535};
    tbl[3] = '{ped: 16'd65535, sig: 16'd0,     exp_data: 28'hFFF0001};
    tbl[4] = '{ped: 16'd1234,  sig: 16'd1234,  exp_data: 28'd0};

    // Reset state
    do_reset();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_nsamp", 64'(out_nsamp), 64'd0);
    chk("rst_err_proto", 64'(err_proto), 64'd0);
    chk("rst_err_ovf", 64'(err_overflow), 64'd0);

    // Single-pair frames, including negative and full-scale differences
    for (int i = 0; i < 5; i++) begin
      start_frame(10'd0, 1'b0);
      pair(tbl[i].ped, tbl[i].sig, 1'b0);
      get_result($sformatf("vec%0d", i), r);
      chk($sformatf("vec%0d_data", i), 64'(r.data), 64'(tbl[i].exp_data));
      chk($sformatf("vec%0d_pixel", i), 64'(r.pix), 64'd0);
      chk($sformatf("vec%0d_nsamp", i), 64'(r.ns), 64'd1);
      chk($sformatf("vec%0d_latency", i), 64'(r.cyc - last_sig_cyc), 64'd2);
    end

    // Skipper accumulation with repeated valids inside each strobe
    start_frame(10'd3, 1'b0);
    pair(16'd10, 16'd20, 1'b1);
    pair(16'd10, 16'd25, 1'b1);
    pair(16'd12, 16'd12, 1'b1);
    pair(16'd0,  16'd5,  1'b1);
    get_result("skip4", r);
    chk("skip4_data", 64'(r.data), 64'd30);
    chk("skip4_nsamp", 64'(r.ns), 64'd4);
    chk("skip4_pixel", 64'(r.pix), 64'd0);

    // Global-shutter cluster of 16 pixels, then FSM back in IDLE
    start_frame(10'd0, 1'b1);
    for (int k = 0; k < 16; k++) pair(16'd0, 16'(k), 1'b0);
    for (int k = 0; k < 16; k++) begin
      get_result($sformatf("gs%0d", k), r);
      chk($sformatf("gs%0d_pixel", k), 64'(r.pix), 64'(k));
      chk($sformatf("gs%0d_data", k), 64'(r.data), 64'(k));
    end
    pair(16'd0, 16'd7, 1'b0);
    repeat (5) @(negedge clk);
    chk("gs_idle_no_result", 64'(q.size()), 64'd0);
    start_frame(10'd0, 1'b0);
    chk("gs_idle_no_proto", 64'(err_proto), 64'd0);

    // SIG before PED
    do_reset();
    start_frame(10'd0, 1'b0);
    strobe(1'b1, 16'd50, 1'b0);
    chk("early_sig_proto", 64'(err_proto), 64'd1);
    chk("early_sig_no_out", 64'(out_valid), 64'd0);
    pair(16'd5, 16'd9, 1'b0);
    get_result("after_proto", r);
    chk("after_proto_data", 64'(r.data), 64'd4);
    chk("after_proto_nsamp", 64'(r.ns), 64'd1);

    // Backpressure and overflow
    do_reset();
    out_ready = 1'b0;
    start_frame(10'd0, 1'b1);
    pair(16'd0, 16'd1, 1'b0);
    pair(16'd0, 16'd2, 1'b0);
    chk("ovf_not_yet", 64'(err_overflow), 64'd0);
    pair(16'd0, 16'd3, 1'b0);
    repeat (3) @(negedge clk);
    chk("ovf_flag", 64'(err_overflow), 64'd1);
    chk("ovf_hold_valid", 64'(out_valid), 64'd1);
    chk("ovf_hold_data", 64'(out_data), 64'd1);
    repeat (3) @(negedge clk);
    chk("ovf_stable_data", 64'(out_data), 64'd1);
    chk("ovf_stable_pixel", 64'(out_pixel), 64'd0);
    out_ready = 1'b1;
    get_result("drain0", r);
    chk("drain0_data", 64'(r.data), 64'd1);
    get_result("drain1", r);
    chk("drain1_data", 64'(r.data), 64'd2);
    chk("drain1_pixel", 64'(r.pix), 64'd1);
    repeat (5) @(negedge clk);
    chk("drain_empty", 64'(q.size()), 64'd0);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    chk("clear_ovf", 64'(err_overflow), 64'd0);
    chk("clear_proto", 64'(err_proto), 64'd0);

    // Frame restart mid-pixel
    do_reset();
    start_frame(10'd3, 1'b0);
    pair(16'd0, 16'd100, 1'b0);
    pair(16'd0, 16'd100, 1'b0);
    chk("restart_pre_proto", 64'(err_proto), 64'd0);
    start_frame(10'd3, 1'b0);
    chk("restart_proto", 64'(err_proto), 64'd1);
    for (int k = 0; k < 4; k++) pair(16'd1, 16'd2, 1'b0);
    get_result("restart", r);
    chk("restart_data", 64'(r.data), 64'd4);
    chk("restart_nsamp", 64'(r.ns), 64'd4);

    // Reset while waiting for SIG with a result held in the buffer
    do_reset();
    out_ready = 1'b0;
    start_frame(10'd0, 1'b1);
    pair(16'd0, 16'd9, 1'b0);
    strobe(1'b0, 16'd1, 1'b0);
    chk("midrst_pre_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_data", 64'(out_data), 64'd0);
    chk("midrst_pixel", 64'(out_pixel), 64'd0);
    chk("midrst_nsamp", 64'(out_nsamp), 64'd0);
    integration = 1'b0;
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_empty", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
